// File: rtl/addsub_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter: widths, op
// encodings, FSM states and the round-robin pick used when both requesters ask.
package addsub_pkg;

    localparam int   DEFAULT_WIDTH = 8;
    localparam int   NUM_REQ       = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // On a tie the requester that did not win last time is chosen.
    function automatic logic rr_grant(input logic [NUM_REQ-1:0] valid,
                                      input logic               last);
        logic pick;
        pick = 1'b0;
        if (valid == 2'b11) begin
            pick = ~last;
        end else if (valid[1]) begin
            pick = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational two's-complement add/subtract with signed-overflow detection;
// one instance is shared by both requesters.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    op,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    logic sign_a;
    logic sign_b;
    logic sign_r;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_SUB:  result = a - b;
            default: result = a + b;
        endcase

        sign_a = a[WIDTH-1];
        sign_b = b[WIDTH-1];
        sign_r = result[WIDTH-1];

        // Add overflows only when like signs produce an unlike result; subtract
        // only when unlike signs produce a result whose sign differs from a.
        if (op == OP_SUB) begin
            ovf = (sign_a != sign_b) && (sign_r != sign_a);
        end else begin
            ovf = (sign_a == sign_b) && (sign_r != sign_a);
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one add/sub unit through a round-robin arbiter and an
// IDLE -> EXEC -> RESP controller with a single outstanding transaction.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic signed [WIDTH-1:0] a0,
    input  logic signed [WIDTH-1:0] b0,
    input  logic                    op0,
    input  logic signed [WIDTH-1:0] a1,
    input  logic signed [WIDTH-1:0] b1,
    input  logic                    op1,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic signed [WIDTH-1:0] rsp_result,
    output logic                    rsp_ovf
);

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;

    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] b_q, b_d;
    logic                    op_q, op_d;
    logic                    id_q, id_d;

    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_id_q, rsp_id_d;
    logic signed [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                    rsp_ovf_q, rsp_ovf_d;

    logic signed [WIDTH-1:0] a_in  [NUM_REQ];
    logic signed [WIDTH-1:0] b_in  [NUM_REQ];
    logic [NUM_REQ-1:0]      op_in;

    logic                    grant_idx;
    logic                    idle_open;
    logic signed [WIDTH-1:0] core_result;
    logic                    core_ovf;

    assign a_in[0] = a0;
    assign b_in[0] = b0;
    assign op_in[0] = op0;
    assign a_in[1] = a1;
    assign b_in[1] = b1;
    assign op_in[1] = op1;

    assign grant_idx = rr_grant(req_valid, last_grant_q);
    // rst_n gates ready so nothing looks accepted while reset is held.
    assign idle_open = rst_n && (state_q == IDLE);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = idle_open && req_valid[gi] && (grant_idx == 1'(gi));
        end
    endgenerate

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .ovf    (core_ovf)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;

        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    a_d          = a_in[grant_idx];
                    b_d          = b_in[grant_idx];
                    op_d         = op_in[grant_idx];
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = core_result;
                rsp_ovf_d    = core_ovf;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ovf    = rsp_ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed vectors push expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_addsub_arbiter;
    import addsub_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic                id;
        logic signed [W-1:0] result;
        logic                ovf;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic signed [W-1:0] a0, b0, a1, b1;
    logic                op0, op1;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic signed [W-1:0] rsp_result;
    logic                rsp_ovf;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a0         (a0),
        .b0         (b0),
        .op0        (op0),
        .a1         (a1),
        .b1         (b1),
        .op1        (op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_rsp(input logic id, input logic signed [W-1:0] r, input logic o);
        exp_t e;
        e.id = id;
        e.result = r;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int idx, input logic signed [W-1:0] a,
                         input logic signed [W-1:0] b, input logic op);
        if (idx == 0) begin
            a0 = a; b0 = b; op0 = op;
        end else begin
            a1 = a; b1 = b; op1 = op;
        end
        req_valid[idx] = 1'b1;
    endtask

    // Waits for requester idx to be accepted, then withdraws it and scrambles its operands.
    task automatic wait_hs(input int idx, output logic [1:0] rdy, output int hcyc);
        bit got;
        got = 0;
        rdy = 2'b00;
        hcyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[idx] && req_valid[idx]) begin
                got = 1;
                rdy = req_ready;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL handshake_timeout: req %0d got no ready, required ready within 40 cycles", idx);
        end else begin
            @(posedge clk);
            hcyc = cyc;
        end
        #1;
        req_valid[idx] = 1'b0;
        if (idx == 0) begin
            a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom);
        end else begin
            a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom);
        end
    endtask

    task automatic wait_rsp();
        bit got;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        check("rsp_appears", 32'(got), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got id=%0d result=%0d ovf=%0d, required no response",
                         rsp_id, rsp_result, rsp_ovf);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] rsp id=%0d result=%0d ovf=%0d (exp id=%0d result=%0d ovf=%0d)",
                         rsp_id, rsp_result, rsp_ovf, mon_e.id, mon_e.result, mon_e.ovf);
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_result", rsp_result, mon_e.result);
                check("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rdy;
        int         hc;
        int         prev_hc;
        int         vid  [6] = '{0, 1, 0, 1, 0, 1};
        int         va   [6] = '{127, -128, -10, 100, -100, -5};
        int         vb   [6] = '{1, 1, 20, -100, -100, 3};
        int         vop  [6] = '{0, 1, 0, 1, 0, 1};
        int         vres [6] = '{-128, 127, 10, -56, 56, -8};
        int         vovf [6] = '{1, 1, 0, 1, 1, 0};

        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        a0 = '0; b0 = '0; op0 = OP_ADD;
        a1 = '0; b1 = '0; op1 = OP_ADD;

        // Reset state, with both requesters asking
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", rsp_result, 32'sd0);
        check("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2 rst_n = 1'b1;

        // Tie right after reset: requester 0 first, then 1; next tie back to 0
        @(posedge clk); #1;
        a0 = 8'sd50; b0 = 8'sd25;  op0 = OP_SUB;
        a1 = 8'sd10; b1 = -8'sd20; op1 = OP_SUB;
        req_valid = 2'b11;
        expect_rsp(1'b0, 8'sd25, 1'b0);
        expect_rsp(1'b1, 8'sd30, 1'b0);
        wait_hs(0, rdy, hc);
        check("tie_first_grant", 32'(rdy), 32'd1);
        wait_hs(1, rdy, hc);
        check("second_grant_req1", 32'(rdy), 32'd2);
        drain();
        @(posedge clk); #1;
        a0 = 8'sd1; b0 = 8'sd2; op0 = OP_ADD;
        a1 = 8'sd9; b1 = 8'sd9; op1 = OP_ADD;
        req_valid = 2'b11;
        expect_rsp(1'b0, 8'sd3, 1'b0);
        wait_hs(0, rdy, hc);
        check("tie_rr_back_to_0", 32'(rdy), 32'd1);
        req_valid = 2'b00;
        drain();

        // Single request: response one edge after handshake
        @(posedge clk); #1;
        expect_rsp(1'b0, 8'sd35, 1'b0);
        issue(0, 8'sd15, 8'sd20, OP_ADD);
        wait_hs(0, rdy, hc);
        @(negedge clk);
        check("exec_rsp_valid_low", 32'(rsp_valid), 32'd0);
        check("exec_req_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rsp_valid_at_n_plus_1", 32'(rsp_valid), 32'd1);
        drain();

        // Overflow/wrap table issued back to back: spacing must be 3 cycles
        @(posedge clk); #1;
        prev_hc = 0;
        for (int i = 0; i < 6; i++) begin
            expect_rsp(1'(vid[i]), W'(vres[i]), 1'(vovf[i]));
            issue(vid[i], W'(va[i]), W'(vb[i]), 1'(vop[i]));
            wait_hs(vid[i], rdy, hc);
            if (i > 0) check("request_spacing", hc - prev_hc, 3);
            prev_hc = hc;
        end
        drain();

        // Backpressure: three cycles of rsp_ready low, stray request ignored
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        expect_rsp(1'b0, 8'sd4, 1'b0);
        issue(0, 8'sd7, -8'sd3, OP_ADD);
        wait_hs(0, rdy, hc);
        issue(1, 8'sd9, 8'sd9, OP_ADD);
        wait_rsp();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_result", rsp_result, 32'sd4);
            check("stall_rsp_id", 32'(rsp_id), 32'd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        check("rsp_valid_dropped", 32'(rsp_valid), 32'd0);

        // Reset in EXEC: transaction dropped, no stale response
        @(posedge clk); #1;
        issue(0, 8'sd1, 8'sd1, OP_ADD);
        wait_hs(0, rdy, hc);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_hold_req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        a0 = 8'sd2; b0 = 8'sd2; op0 = OP_ADD;
        a1 = 8'sd5; b1 = 8'sd5; op1 = OP_ADD;
        req_valid = 2'b11;
        expect_rsp(1'b0, 8'sd4, 1'b0);
        wait_hs(0, rdy, hc);
        check("tie_after_reset", 32'(rdy), 32'd1);
        req_valid = 2'b00;
        drain();

        // Reset while a response is being held
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1, 8'sd5, 8'sd6, OP_ADD);
        wait_hs(1, rdy, hc);
        wait_rsp();
        check("resp_before_rst_result", rsp_result, 32'sd11);
        rst_n = 1'b0;
        #1;
        check("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_resp_rsp_result", rsp_result, 32'sd0);
        check("rst_resp_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale_after_resp_rst", 32'(rsp_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (two's complement).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 SHALL have port: req_ready  output  2  per-requester request accepted this cycle.
REQ-006 SHALL have ports: a0, b0  input  WIDTH signed  requester-0 operands; op0  input  1  requester-0 op (0 add, 1 subtract).
REQ-007 SHALL have ports: a1, b1  input  WIDTH signed  requester-1 operands; op1  input  1  requester-1 op.
REQ-008 SHALL have port: rsp_valid  output  1  response available.
REQ-009 SHALL have port: rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port: rsp_id  output  1  requester index owning the response.
REQ-011 SHALL have port: rsp_result  output  WIDTH signed  a+b or a-b, modulo 2^WIDTH.
REQ-012 SHALL have port: rsp_ovf  output  1  signed overflow of the operation.

Function
REQ-013 SHALL implement FSM with states IDLE, EXEC, RESP; one transaction outstanding at a time.
REQ-014 SHALL, in IDLE, grant exactly one valid requester: sole valid requester wins; both valid -> requester not granted last (round-robin).
REQ-015 SHALL drive req_ready[i] high only in IDLE and only for the granted requester (may depend combinationally on req_valid); req_ready = 2'b00 in EXEC and RESP.
REQ-016 SHALL, on handshake (req_valid[i] & req_ready[i]) at edge N, capture a_i, b_i, op_i, id=i, update last-grant to i, enter EXEC.
REQ-017 SHALL, in EXEC, compute via the shared add/sub unit and register rsp_result, rsp_ovf, rsp_id at edge N+1, enter RESP; rsp_valid high from edge N+1.
REQ-018 SHALL hold rsp_valid, rsp_id, rsp_result, rsp_ovf stable in RESP until rsp_valid & rsp_ready; then return to IDLE, rsp_valid low next cycle.
REQ-019 SHALL give minimum request-to-request spacing of 3 cycles (IDLE, EXEC, RESP with rsp_ready high).
REQ-020 SHALL set overflow for add when a,b share sign and result sign differs; for subtract when a,b differ in sign and result sign differs from a.
REQ-021 SHALL wrap results: 127+1 -> -128, -128-1 -> 127 at WIDTH=8.
REQ-022 SHALL ignore req_valid changes outside IDLE; operands latched at handshake are not affected by later input changes.

Reset
REQ-023 SHALL on rst_n low, immediately and regardless of state: state IDLE, rsp_valid 0, rsp_result 0, rsp_ovf 0, rsp_id 0, last-grant 1 (requester 0 wins first tie).
REQ-024 SHALL drop an in-flight transaction on reset mid-operation; no response issued for it after release.
REQ-025 SHALL keep req_ready 2'b00 while rst_n low.

Structure
REQ-026 SHALL place in shared package addsub_pkg: default WIDTH, OP_ADD/OP_SUB encodings, FSM state typedef.
REQ-027 SHALL instantiate one combinational sub-module addsub_core (a, b, op -> result, ovf) shared by both requesters.

Verification
REQ-028 SHALL cover: req 0 alone a=15,b=20,op=0 -> rsp_valid at N+1, result 35, ovf 0, id 0.
REQ-029 SHALL cover: both valid after reset, req0 50-25, req1 10-(-20) -> first rsp id 0 result 25, then id 1 result 30; next tie grants 0.
REQ-030 SHALL cover: 127+1 -> result -128, ovf 1; -128-1 -> result 127, ovf 1; -10+20 -> 10, ovf 0.
REQ-031 SHALL cover: rsp_ready low 3 cycles -> rsp outputs stable, req_ready 2'b00 throughout; accepted on 4th.
REQ-032 SHALL cover: rst_n low during EXEC -> rsp_valid 0 immediately, state IDLE, no stale response after release.
